// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Interrupt factor/mask register file for a 4-bit CPU. Timer,
//            stopwatch, programmable-timer, serial and optional K-port
//            falling-edge events latch factor flags. The CPU reads a flag
//            register to clear it. A factor ANDed with its mask drives a bit
//            of the interrupt request vector.
// Ports    : clk, reset (sync, active high), clk_en (CPU-rate enable)
//            memory_addr/read_en/write_en/write_data  - CPU bus inputs
//            memory_read_data/memory_read_hit         - register readback
//            ev_clock[3:0], ev_stopwatch[1:0], ev_prog_timer, ev_serial
//            k0_in[3:0], k1_in[3:0]                   - synchronised K pins
//            interrupt_req[14:0]                      - request vector
// Config   : define INTERRUPT_K_INPUT_EN to build the K-port edge logic
//            (IK0/IK1/EIK0/EIK1). Without it those registers read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic [11:0] memory_addr,
   input  logic        memory_read_en,
   input  logic        memory_write_en,
   input  logic [3:0]  memory_write_data,
   output logic [3:0]  memory_read_data,
   output logic        memory_read_hit,
   input  logic [3:0]  ev_clock,
   input  logic [1:0]  ev_stopwatch,
   input  logic        ev_prog_timer,
   input  logic        ev_serial,
   input  logic [3:0]  k0_in,
   input  logic [3:0]  k1_in,
   output logic [14:0] interrupt_req
);

   // Factor (flag) registers
   logic [3:0] it;
   logic [1:0] isw;
   logic       ipt;
   logic       isio;
   logic       ik0;
   logic       ik1;
   // Mask registers
   logic [3:0] eit;
   logic [1:0] eisw;
   logic       eipt;
   logic       eisio;
   logic [3:0] eik0;
   logic [3:0] eik1;

   // Bus decode: a read of a factor register clears it at the edge ending it.
   logic rd_it, rd_isw, rd_ipt, rd_isio, rd_ik0, rd_ik1;
   logic wr_eit, wr_eisw, wr_eipt, wr_eisio, wr_eik0, wr_eik1;

   assign rd_it    = memory_read_en  && (memory_addr == 12'hF00);
   assign rd_isw   = memory_read_en  && (memory_addr == 12'hF01);
   assign rd_ipt   = memory_read_en  && (memory_addr == 12'hF02);
   assign rd_isio  = memory_read_en  && (memory_addr == 12'hF03);
   assign rd_ik0   = memory_read_en  && (memory_addr == 12'hF04);
   assign rd_ik1   = memory_read_en  && (memory_addr == 12'hF05);
   assign wr_eit   = memory_write_en && (memory_addr == 12'hF10);
   assign wr_eisw  = memory_write_en && (memory_addr == 12'hF11);
   assign wr_eipt  = memory_write_en && (memory_addr == 12'hF12);
   assign wr_eisio = memory_write_en && (memory_addr == 12'hF13);
   assign wr_eik0  = memory_write_en && (memory_addr == 12'hF14);
   assign wr_eik1  = memory_write_en && (memory_addr == 12'hF15);

   // Core factors and masks. The event is ORed after the read-clear so a
   // flag raised on the same edge as its clearing read survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         it    <= 4'h0;
         isw   <= 2'h0;
         ipt   <= 1'b0;
         isio  <= 1'b0;
         eit   <= 4'h0;
         eisw  <= 2'h0;
         eipt  <= 1'b0;
         eisio <= 1'b0;
      end else if (clk_en) begin
         it   <= (rd_it   ? 4'h0 : it)   | ev_clock;
         isw  <= (rd_isw  ? 2'h0 : isw)  | ev_stopwatch;
         ipt  <= (rd_ipt  ? 1'b0 : ipt)  | ev_prog_timer;
         isio <= (rd_isio ? 1'b0 : isio) | ev_serial;
         if (wr_eit)   eit   <= memory_write_data;
         if (wr_eisw)  eisw  <= memory_write_data[1:0];
         if (wr_eipt)  eipt  <= memory_write_data[0];
         if (wr_eisio) eisio <= memory_write_data[0];
      end
   end

`ifdef INTERRUPT_K_INPUT_EN
   logic [3:0] k0_prev;
   logic [3:0] k1_prev;
   logic       k0_fall;
   logic       k1_fall;

   // Mask is applied at the edge itself, so enabling a mask later never
   // replays an edge that was already missed.
   assign k0_fall = |(k0_prev & ~k0_in & eik0);
   assign k1_fall = |(k1_prev & ~k1_in & eik1);

   always_ff @(posedge clk) begin
      if (reset) begin
         // Seed history with live pin levels so no edge appears after reset.
         k0_prev <= k0_in;
         k1_prev <= k1_in;
         ik0     <= 1'b0;
         ik1     <= 1'b0;
         eik0    <= 4'h0;
         eik1    <= 4'h0;
      end else if (clk_en) begin
         k0_prev <= k0_in;
         k1_prev <= k1_in;
         ik0     <= (rd_ik0 ? 1'b0 : ik0) | k0_fall;
         ik1     <= (rd_ik1 ? 1'b0 : ik1) | k1_fall;
         if (wr_eik0) eik0 <= memory_write_data;
         if (wr_eik1) eik1 <= memory_write_data;
      end
   end
`else
   logic unused_k_inputs;

   assign ik0  = 1'b0;
   assign ik1  = 1'b0;
   assign eik0 = 4'h0;
   assign eik1 = 4'h0;
   assign unused_k_inputs = ^{k0_in, k1_in, rd_ik0, rd_ik1, wr_eik0, wr_eik1};
`endif

   // Combinational register readback
   always_comb begin
      memory_read_data = 4'h0;
      memory_read_hit  = 1'b0;
      if (memory_read_en) begin
         memory_read_hit = 1'b1;
         case (memory_addr)
            12'hF00: memory_read_data = it;
            12'hF01: memory_read_data = {2'b00, isw};
            12'hF02: memory_read_data = {3'b000, ipt};
            12'hF03: memory_read_data = {3'b000, isio};
            12'hF04: memory_read_data = {3'b000, ik0};
            12'hF05: memory_read_data = {3'b000, ik1};
            12'hF10: memory_read_data = eit;
            12'hF11: memory_read_data = {2'b00, eisw};
            12'hF12: memory_read_data = {3'b000, eipt};
            12'hF13: memory_read_data = {3'b000, eisio};
            12'hF14: memory_read_data = eik0;
            12'hF15: memory_read_data = eik1;
            default: memory_read_hit  = 1'b0;
         endcase
      end
   end

   // K factors are already masked at the edge, so they drive requests directly.
   always_comb begin
      interrupt_req     = 15'h0000;
      interrupt_req[1]  = |(it & eit);
      interrupt_req[3]  = |(isw & eisw);
      interrupt_req[5]  = ik0;
      interrupt_req[7]  = isio & eisio;
      interrupt_req[9]  = ik1;
      interrupt_req[11] = ipt & eipt;
   end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Self-checking bench for interrupt_controller. A register-array
//            reference model predicts readback, hit and request outputs.
//            Directed scenarios come first, then randomized traffic.
// Config   : honours INTERRUPT_K_INPUT_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

`ifdef INTERRUPT_K_INPUT_EN
   localparam bit K_EN = 1'b1;
`else
   localparam bit K_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        clk_en;
   logic [11:0] memory_addr;
   logic        memory_read_en;
   logic        memory_write_en;
   logic [3:0]  memory_write_data;
   logic [3:0]  memory_read_data;
   logic        memory_read_hit;
   logic [3:0]  ev_clock;
   logic [1:0]  ev_stopwatch;
   logic        ev_prog_timer;
   logic        ev_serial;
   logic [3:0]  k0_in;
   logic [3:0]  k1_in;
   logic [14:0] interrupt_req;

   interrupt_controller dut (
      .clk               (clk),
      .reset             (reset),
      .clk_en            (clk_en),
      .memory_addr       (memory_addr),
      .memory_read_en    (memory_read_en),
      .memory_write_en   (memory_write_en),
      .memory_write_data (memory_write_data),
      .memory_read_data  (memory_read_data),
      .memory_read_hit   (memory_read_hit),
      .ev_clock          (ev_clock),
      .ev_stopwatch      (ev_stopwatch),
      .ev_prog_timer     (ev_prog_timer),
      .ev_serial         (ev_serial),
      .k0_in             (k0_in),
      .k1_in             (k1_in),
      .interrupt_req     (interrupt_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_value(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Index 0..5 = IT, ISW, IPT, ISIO, IK0, IK1 / EIT, EISW, EIPT, EISIO, EIK0, EIK1
   int fac[6];
   int msk[6];
   int fac_w[6] = '{15, 3, 1, 1, 1, 1};
   int msk_w[6];
   int prev_k0, prev_k1;

   function automatic int fac_idx(input int a);
      return (a >= 'hF00 && a <= 'hF05) ? a - 'hF00 : -1;
   endfunction

   function automatic int msk_idx(input int a);
      return (a >= 'hF10 && a <= 'hF15) ? a - 'hF10 : -1;
   endfunction

   function automatic int m_rd();
      int a = int'(memory_addr);
      if (!memory_read_en) return 0;
      if (fac_idx(a) >= 0) return fac[fac_idx(a)];
      if (msk_idx(a) >= 0) return msk[msk_idx(a)];
      return 0;
   endfunction

   function automatic int m_hit();
      int a = int'(memory_addr);
      return (memory_read_en && (fac_idx(a) >= 0 || msk_idx(a) >= 0)) ? 1 : 0;
   endfunction

   function automatic int m_irq();
      int r = 0;
      if ((fac[0] & msk[0]) != 0) r += 2;
      if ((fac[1] & msk[1]) != 0) r += 8;
      if (fac[4] != 0)            r += 32;
      if ((fac[3] & msk[3]) != 0) r += 128;
      if (fac[5] != 0)            r += 512;
      if ((fac[2] & msk[2]) != 0) r += 2048;
      return r;
   endfunction

   task automatic model_update();
      int nf[6];
      int nm[6];
      int a = int'(memory_addr);
      int k0 = int'(k0_in);
      int k1 = int'(k1_in);
      if (reset) begin
         for (int i = 0; i < 6; i++) begin fac[i] = 0; msk[i] = 0; end
         prev_k0 = k0;
         prev_k1 = k1;
      end else if (clk_en) begin
         nf = fac;
         nm = msk;
         if (memory_read_en && fac_idx(a) >= 0) nf[fac_idx(a)] = 0;
         nf[0] = nf[0] | int'(ev_clock);
         nf[1] = nf[1] | int'(ev_stopwatch);
         nf[2] = nf[2] | int'(ev_prog_timer);
         nf[3] = nf[3] | int'(ev_serial);
         if (K_EN) begin
            // falling edge on any pin whose mask is set at this edge
            if ((prev_k0 & ~k0 & msk[4]) != 0) nf[4] = 1;
            if ((prev_k1 & ~k1 & msk[5]) != 0) nf[5] = 1;
         end
         prev_k0 = k0;
         prev_k1 = k1;
         if (memory_write_en && msk_idx(a) >= 0)
            nm[msk_idx(a)] = int'(memory_write_data) & msk_w[msk_idx(a)];
         fac = nf;
         msk = nm;
      end
   endtask

   // One clock: compare outputs at the falling edge, then advance the model.
   task automatic tick();
      @(negedge clk);
      check_value("rd_data", int'(memory_read_data), m_rd());
      check_value("rd_hit",  int'(memory_read_hit),  m_hit());
      check_value("irq",     int'(interrupt_req),    m_irq());
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; clk_en = 1'b1;
      memory_addr = 12'h000; memory_read_en = 1'b0; memory_write_en = 1'b0;
      memory_write_data = 4'h0;
      ev_clock = 4'h0; ev_stopwatch = 2'h0; ev_prog_timer = 1'b0; ev_serial = 1'b0;
   endtask

   task automatic set_wr(input logic [11:0] a, input logic [3:0] d);
      idle();
      memory_addr = a; memory_write_en = 1'b1; memory_write_data = d;
   endtask

   task automatic set_rd(input logic [11:0] a);
      idle();
      memory_addr = a; memory_read_en = 1'b1;
   endtask

   task automatic randomize_inputs();
      int r;
      clk_en = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 63) == 0);
      ev_clock      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      ev_stopwatch  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'h0;
      ev_prog_timer = ($urandom_range(0, 5) == 0);
      ev_serial     = ($urandom_range(0, 5) == 0);
      memory_read_en  = ($urandom_range(0, 1) == 0);
      memory_write_en = ($urandom_range(0, 2) == 0);
      memory_write_data = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 15));
      if (r < 6)       memory_addr = 12'('hF00 + r);
      else if (r < 12) memory_addr = 12'('hF10 + r - 6);
      else             memory_addr = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 2) == 0) k0_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) k1_in = 4'($urandom_range(0, 15));
   endtask

   initial begin
      for (int i = 0; i < 6; i++) msk_w[i] = (i < 4) ? fac_w[i] : (K_EN ? 15 : 0);
      msk_w[0] = 15;
      k0_in = 4'hF; k1_in = 4'hF;
      idle();
      reset = 1'b1;
      @(posedge clk);
      model_update();
      #1;
      idle();
      #3; check_value("rst_irq", int'(interrupt_req), 0);
      tick();

      // Masked timer event, then clearing read
      set_wr(12'hF10, 4'h1); tick();
      idle(); ev_clock = 4'h1; tick();
      idle(); #3; check_value("t25_irq", int'(interrupt_req), 'h0002); tick();
      set_rd(12'hF00); #3; check_value("t25_rd", int'(memory_read_data), 1); tick();
      idle(); #3; check_value("t25_irq_clr", int'(interrupt_req), 0); tick();
      set_rd(12'hF00); #3; check_value("t25_rd_clr", int'(memory_read_data), 0); tick();

      // Event sets factor while masked off; enabling mask raises request
      set_wr(12'hF10, 4'h0); tick();
      idle(); ev_clock = 4'h8; tick();
      idle(); #3; check_value("t26_irq_off", int'(interrupt_req), 0); tick();
      set_wr(12'hF10, 4'h8); tick();
      idle(); #3; check_value("t26_irq_on", int'(interrupt_req), 'h0002); tick();
      set_rd(12'hF00); #3; check_value("t26_rd", int'(memory_read_data), 8); tick();

      // Event coincident with clearing read wins
      set_wr(12'hF12, 4'h1); tick();
      set_rd(12'hF02); ev_prog_timer = 1'b1; #3;
      check_value("t27_rd_prior", int'(memory_read_data), 0); tick();
      set_rd(12'hF02); #3; check_value("t27_rd_kept", int'(memory_read_data), 1);
      check_value("t27_irq", int'(interrupt_req), 'h0800); tick();
      set_rd(12'hF02); #3; check_value("t27_rd_clr", int'(memory_read_data), 0); tick();

      // K-port falling edges
      set_wr(12'hF14, 4'h4); tick();
      idle(); k0_in = 4'hB; tick();
      idle(); #3; check_value("t28_irq", int'(interrupt_req), K_EN ? 'h0020 : 0); tick();
      set_rd(12'hF04); tick();
      idle(); k0_in = 4'hF; tick();
      idle(); k0_in = 4'hE; tick();
      idle(); #3; check_value("t28_nomask", int'(interrupt_req), 0); tick();
      // Enabling a mask later must not replay the missed edge
      set_wr(12'hF14, 4'h1); tick();
      idle(); #3; check_value("t28_noretro", int'(interrupt_req), 0); tick();
      k0_in = 4'hF; k1_in = 4'hF;

      // Reset discards pending state
      set_wr(12'hF11, 4'h3); ev_clock = 4'hF; ev_stopwatch = 2'h3; tick();
      set_wr(12'hF10, 4'hF); ev_serial = 1'b1; reset = 1'b1; tick();
      idle(); #3; check_value("t29_irq_rst", int'(interrupt_req), 0); tick();
      for (int i = 0; i < 12; i++) begin
         set_rd(12'((i < 6) ? 'hF00 + i : 'hF10 + i - 6));
         #3; check_value("t29_rd_rst", int'(memory_read_data), 0);
         tick();
      end
      // clk_en low freezes factors
      set_wr(12'hF10, 4'hF); clk_en = 1'b0; ev_clock = 4'hF;
      ev_prog_timer = 1'b1; ev_serial = 1'b1; tick();
      set_rd(12'hF00); #3; check_value("t29_ce_it", int'(memory_read_data), 0); tick();
      set_rd(12'hF10); #3; check_value("t29_ce_eit", int'(memory_read_data), 0); tick();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         randomize_inputs();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous active-high reset, sampled on rising clk, independent of clk_en.
REQ-003 SHALL have port clk_en  in  1  CPU-rate enable; all state updates except reset are qualified by clk_en.
REQ-004 SHALL have ports memory_addr  in  12, memory_read_en  in  1, memory_write_en  in  1, memory_write_data  in  4; CPU data-bus view.
REQ-005 SHALL have ports memory_read_data  out  4 and memory_read_hit  out  1; register readback and address-decode hit.
REQ-006 SHALL have ports ev_clock  in  4 (32/8/2/1 Hz), ev_stopwatch  in  2 (100/10 Hz), ev_prog_timer  in  1, ev_serial  in  1; single-clk_en event pulses.
REQ-007 SHALL have ports k0_in  in  4 and k1_in  in  4; raw K-port levels, already synchronised to clk.
REQ-008 SHALL have port interrupt_req  out  15; request vector consumed by the CPU.

Function
REQ-009 SHALL hold factor registers (fire on event, cleared by CPU read): IT[3:0] at 0xF00, ISW[1:0] at 0xF01, IPT at 0xF02, ISIO at 0xF03, IK0 at 0xF04, IK1 at 0xF05.
REQ-010 SHALL hold read/write mask registers: EIT[3:0] 0xF10, EISW[1:0] 0xF11, EIPT 0xF12, EISIO 0xF13, EIK0[3:0] 0xF14, EIK1[3:0] 0xF15; unused bits read 0.
REQ-011 SHALL set factor bit n when its event pulse is high with clk_en; an event sets its factor bit regardless of mask state.
REQ-012 SHALL return factor/mask contents combinationally on memory_read_data, with memory_read_hit=1, when memory_read_en=1 and memory_addr hits REQ-009/010; otherwise memory_read_data=0, memory_read_hit=0.
REQ-013 SHALL clear all bits of an addressed factor register at the clk_en edge that ends a read of it; mask reads have no side effect.
REQ-014 SHALL keep a factor bit set when its event and a clearing read occur at the same clk_en edge; the event wins and is not lost.
REQ-015 SHALL write memory_write_data into an addressed mask register at clk_en when memory_write_en=1; writes to factor addresses are ignored.
REQ-016 SHALL drive interrupt_req combinationally from registers: bit1=|(IT&EIT), bit3=|(ISW&EISW), bit5=IK0, bit7=ISIO&EISIO, bit9=IK1, bit11=IPT&EIPT; all other bits 0.
REQ-017 SHALL, per K pin, register previous level each clk_en and set IK0/IK1 on a falling edge (1->0) of any pin whose EIK bit is 1; one-clk_en-cycle latency from edge to factor bit.
REQ-018 SHALL not raise K edges from a pin whose mask bit is 0 at the edge; later enabling the mask SHALL NOT retroactively fire.
REQ-019 SHALL hold all state unchanged when clk_en=0, including edge-detect history.

Reset
REQ-020 SHALL clear all factor and mask registers and the interrupt_req output to 0 on reset.
REQ-021 SHALL load edge-detect history with current k0_in/k1_in on reset so no edge is seen on the first cycle afterward.
REQ-022 SHALL give reset priority over simultaneous events, reads and writes; reset asserted mid-operation discards pending factors.

Configuration
REQ-023 SHALL compile K-port edge logic only when INTERRUPT_K_INPUT_EN is defined.
REQ-024 SHALL, without INTERRUPT_K_INPUT_EN, read IK0/IK1/EIK0/EIK1 as 0, ignore writes to them, and tie interrupt_req bits 5 and 9 to 0; all other behaviour unchanged.

Verification
REQ-025 SHALL cover: write EIT=0x1, pulse ev_clock=0x1 -> IT=0x1, interrupt_req=0x0002 next cycle; read 0xF00 returns 0x1, then IT=0, interrupt_req=0.
REQ-026 SHALL cover: EIT=0, ev_clock=0x8 -> IT reads 0x8, interrupt_req=0; then EIT=0x8 -> interrupt_req bit1=1 without a new event.
REQ-027 SHALL cover: ev_prog_timer pulse at the same clk_en edge as read of 0xF02 -> read returns prior value, IPT=1 afterward.
REQ-028 SHALL cover: EIK0=0x4, k0_in 0xF->0xB -> IK0=1, interrupt_req=0x0020; k0_in 0xF->0xE with EIK0=0x4 -> no set; with macro undefined -> interrupt_req stays 0.
REQ-029 SHALL cover: events and mask writes pending, reset for one cycle -> all reads 0, interrupt_req=0; clk_en=0 with event pulses -> no factor change.
